// File: rtl/core_mem_responder.sv
// Memory-side responder for the core's 24-bit address bus: registered reads, one write per we edge, side loader.
// Optional feature: define MEM_IMEM_PROTECT_EN to reject core writes at or above IMEM_BASE.
module core_mem_responder #(
  parameter int unsigned DEPTH     = 32768,
  parameter int unsigned IMEM_BASE = 9216
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] addrin,
  input  logic [15:0] datain,
  output logic [15:0] dataout,
  input  logic        load_valid,
  input  logic [14:0] load_addr,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic        wr_pulse,
  output logic [15:0] wr_count,
  output logic        err_oob
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_IMEM_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CWRITE = 2'd1,
    S_LOAD   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [15:0] dataout_q, dataout_d;
  logic        wr_pulse_q, wr_pulse_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic        err_q, err_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        mem_we_c;

  logic [15:0] mem [DEPTH];

  // Address word decode
  logic        we;
  logic [7:0]  rsv;
  logic [14:0] a;
  logic        wr_edge, acc_ok, in_imem, core_ok, pend_ok;
  logic [15:0] rd_word;

  assign we      = addrin[23];
  assign rsv     = addrin[22:15];
  assign a       = addrin[14:0];
  assign wr_edge = we & ~we_q;
  assign acc_ok  = (rsv == 8'd0) && (32'(a) < DEPTH);
  assign in_imem = 32'(a) >= IMEM_BASE;
  assign core_ok = acc_ok & ~(PROTECT & in_imem);
  assign pend_ok = 32'(addr_q) < DEPTH;
  assign rd_word = mem[a[AW-1:0]];

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b1;
      dataout_q  <= 16'd0;
      wr_pulse_q <= 1'b0;
      wr_count_q <= 16'd0;
      err_q      <= 1'b0;
      addr_q     <= 15'd0;
      data_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      we_q       <= we;
      dataout_q  <= dataout_d;
      wr_pulse_q <= wr_pulse_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // A reset in the commit cycle abandons the pending write
  always_ff @(posedge clock) begin
    if (mem_we_c && !reset) begin
      mem[addr_q[AW-1:0]] <= data_q;
    end
  end

  // Next-state logic: a core write edge takes priority over the loader
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (wr_edge) begin
          if (core_ok) state_d = S_CWRITE;
        end else if (load_valid) begin
          state_d = S_LOAD;
        end
      end
      S_CWRITE: state_d = S_IDLE;
      S_LOAD:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    dataout_d  = dataout_q;
    wr_pulse_d = 1'b0;
    wr_count_d = wr_count_q;
    err_d      = err_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mem_we_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        dataout_d = acc_ok ? rd_word : 16'd0;
        if (wr_edge) begin
          if (core_ok) begin
            addr_d     = a;
            data_d     = datain;
            wr_pulse_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (load_valid) begin
          addr_d = load_addr;
          data_d = load_data;
        end
      end
      S_CWRITE: begin
        mem_we_c   = pend_ok;
        wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
      end
      S_LOAD: begin
        mem_we_c = pend_ok;
      end
      default: ;
    endcase
  end

  assign load_ready = ~reset & (state_q == S_IDLE) & ~wr_edge;
  assign dataout    = dataout_q;
  assign wr_pulse   = wr_pulse_q;
  assign wr_count   = wr_count_q;
  assign err_oob    = err_q;

endmodule

// File: doc/core_mem_responder.md
# core_mem_responder

Memory-side responder for the core's 24-bit address bus: the target end of the interface that the core drives. It decodes the core's packed address word, which carries a write-enable flag, a reserved field and a 15-bit word address. It returns registered read data and commits each write strobe exactly once into a single-port 16-bit RAM. A side loader port preloads program words, for example at the instruction region base, without a separate memory model.

## Interface
- `DEPTH`, default 32768: number of 16-bit words implemented; addresses ≥ DEPTH are out of range.
- `IMEM_BASE`, default 9216: first word of the instruction region; used only by the protect feature.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `addrin`  in  24  core address word: [23] = we, [22:15] = reserved (must be 0), [14:0] = word address.
- `datain`  in  16  core write data.
- `dataout`  out  16  registered read data to the core.
- `load_valid`  in  1  loader word present.
- `load_addr`  in  15  loader word address.
- `load_data`  in  16  loader word.
- `load_ready`  out  1  loader word accepted this cycle when `load_valid` is also high.
- `wr_pulse`  out  1  one-cycle strobe when a core write commits.
- `wr_count`  out  16  committed core writes; saturates at 0xFFFF.
- `err_oob`  out  1  sticky error flag; cleared only by reset.

## Operation
- Decode: `we = addrin[23]`, `a = addrin[14:0]`, `rsv = addrin[22:15]`.
- An access is invalid if `rsv != 0` or `a >= DEPTH`.
- Reads run continuously:
  - In IDLE, `dataout <= mem[a]` every cycle.
  - Invalid addresses read 0.
- Write detection: register `we_q <= we` every cycle. A write edge is `we & ~we_q`.
  - A `we` held high for any number of cycles produces exactly one write.
  - Changing `a` while `we` stays high produces no further write.
- FSM states: IDLE, CWRITE, LOAD.
  - IDLE, write edge, access valid: latch `a` and `datain`, go to CWRITE.
  - IDLE, write edge, access invalid: set `err_oob`, write dropped, stay in IDLE.
  - IDLE, no write edge, `load_valid` high: latch `load_addr` and `load_data`, go to LOAD.
  - CWRITE: write RAM, `wr_pulse = 1`, `wr_count += 1` (saturating), return to IDLE.
  - LOAD: write RAM, `wr_count` unchanged, return to IDLE.
  - A loader address ≥ DEPTH is accepted but discarded.
- `load_ready = (state == IDLE) & ~(write edge)`, combinational.
- Simultaneous write edge and `load_valid`: the core write wins; the load is accepted on the first following IDLE cycle.
- In CWRITE and LOAD, `dataout` holds its previous value.
- Memory contents are not initialised or reset.

## Timing
- Read latency:
  - `addrin` stable at cycle N gives `dataout` valid after edge N.
  - Read-after-write: the IDLE cycle after CWRITE returns the new data.
- Core write: edge seen at cycle N; RAM written and `wr_pulse` high during cycle N+1; IDLE again at N+2.
- Loader throughput: one word per 2 cycles (handshake cycle plus LOAD cycle).
- Reset values:
  - `dataout` = 0, `wr_pulse` = 0, `wr_count` = 0, `err_oob` = 0, state = IDLE.
  - `load_ready` is 0 while `reset` is high.
  - `we_q` resets to 1, so a `we` held high across reset release does not write. The first write needs `we` to go low and then high again.
- Reset during CWRITE or LOAD: the pending write is abandoned and the RAM is not written.

## Configuration
- `MEM_IMEM_PROTECT_EN` defined: a core write edge to a valid `a >= IMEM_BASE` is dropped.
  - `err_oob` is set; no CWRITE, no `wr_pulse`, no count.
  - Loader writes are unaffected.
- Not defined: core writes anywhere below DEPTH commit normally.

## Test plan
- Preload and read: after reset, load 0x0002 at address 9216, then drive `addrin` = 0x002400 → `dataout` = 0x0002 one cycle later.
- Single write per strobe: `addrin` = 0x800005, `datain` = 0x1234, held 20 cycles → exactly one `wr_pulse`, `wr_count` = 1. Then `addrin` = 0x000005 → `dataout` = 0x1234.
- Collision:
  - Stimulus: `load_valid` with address 10 and data 0xBEEF, asserted in the same cycle as the edge of `addrin` = 0x800003 with `datain` = 0x0007.
  - Required: `load_ready` = 0 that cycle, core write commits first, load accepted 2 cycles later.
  - Both words read back correctly.
- Invalid address:
  - With DEPTH = 16384, a write to 0x804000 → `err_oob` = 1, `wr_count` unchanged, read returns 0.
  - A write to 0x810005 → also rejected.
- Protect: write to 0x802400 with 0x00FF.
  - With `MEM_IMEM_PROTECT_EN`: word unchanged and `err_oob` = 1.
  - Without: word = 0x00FF and `err_oob` = 0.
- Reset with `we` high: hold `addrin` = 0x800007 through a reset pulse → no write and `wr_count` = 0. Dropping `we` and raising it again → one write.
